// File: rtl/iv_bus_pkg.sv
// Shared definitions for the IV-bus I/O controller.
// Optional feature macro used by this block: IV_BUS_AUTOINC_EN (address auto-increment on WC).
package iv_bus_pkg;

  // Pointer width for a power-of-two FIFO of the given depth.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: one extra bit so "full" is representable.
  function automatic int unsigned count_width(int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/iv_wr_fifo.sv
// Synchronous posted-write FIFO of IV-bus write entries.
// A push while full is accepted only when a pop happens in the same cycle.
module iv_wr_fifo
  import iv_bus_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  entry_t                        wdata,
  output entry_t                        rdata,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(Depth)-1:0] count
);

  localparam int unsigned AW = ptr_width(Depth);
  localparam int unsigned CW = count_width(Depth);

  entry_t          mem_q [Depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; reset discards all queued entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (cnt_q == CW'(Depth));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/iv_bus_ctrl.sv
// Parametrised IV-bus I/O controller: per-bank address/data latches on an inverted bus,
// posted-write FIFO replaying WC writes to an external valid/ready bus, sticky overflow flag.
// Define IV_BUS_AUTOINC_EN to post-increment the bank address on WC without SC.
module iv_bus_ctrl
  import iv_bus_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned NBANK      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned BW        = $clog2(NBANK)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_sc,
  input  logic                io_wc,
  input  logic [BW-1:0]       io_bank_w,
  input  logic [BW-1:0]       io_bank_r,
  input  logic [DW-1:0]       n_iv_out,
  output logic [DW-1:0]       n_iv_in,
  input  logic [NBANK*DW-1:0] ext_rd_data,
  output logic [NBANK*DW-1:0] bank_addr,
  output logic [NBANK*DW-1:0] bank_dout,
  output logic                ext_wr_valid,
  input  logic                ext_wr_ready,
  output logic [BW-1:0]       ext_wr_bank,
  output logic [DW-1:0]       ext_wr_addr,
  output logic [DW-1:0]       ext_wr_data,
  output logic                io_stall,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int unsigned CW = count_width(FIFO_DEPTH);

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } iv_wr_entry_t;

  logic [DW-1:0] addr_q [NBANK];
  logic [DW-1:0] addr_d [NBANK];
  logic [DW-1:0] data_q [NBANK];
  logic [DW-1:0] data_d [NBANK];
  logic [DW-1:0] iv_val, cur_addr, wr_addr;
  logic          bank_ok, sc_en, wc_en;
  logic          pop, push, drop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_d;
  iv_wr_entry_t  push_entry, head;

  // Bus is inverted; out-of-range banks silently ignore SC/WC.
  assign iv_val  = ~n_iv_out;
  assign bank_ok = ({1'b0, io_bank_w} < (BW + 1)'(NBANK));
  assign sc_en   = io_sc & bank_ok;
  assign wc_en   = io_wc & bank_ok;

  // Address carried by a write: SC in the same cycle overrides the latched value.
  always_comb begin
    cur_addr = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (io_bank_w == BW'(b)) cur_addr = addr_q[b];
    end
    wr_addr = sc_en ? iv_val : cur_addr;
  end

  // Latch next-state for the selected bank.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (io_bank_w == BW'(b)) begin
        if (sc_en) begin
          addr_d[b] = iv_val;
`ifdef IV_BUS_AUTOINC_EN
        end else if (wc_en) begin
          addr_d[b] = wr_addr + DW'(1);
`endif
        end
        if (wc_en) data_d[b] = iv_val;
      end
    end
  end

  // Latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        addr_q[b] <= '0;
        data_q[b] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop  = ~fifo_empty & ext_wr_ready;
  assign push = wc_en & (~fifo_full | pop);
  assign drop = wc_en & fifo_full & ~pop;

  assign push_entry = '{bank: io_bank_w, addr: wr_addr, data: iv_val};

  iv_wr_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (iv_wr_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow: a drop beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  // Pack latches onto flat buses and drive the inverted read mux.
  always_comb begin
    n_iv_in = '1;
    for (int unsigned b = 0; b < NBANK; b++) begin
      bank_addr[b*DW +: DW] = addr_q[b];
      bank_dout[b*DW +: DW] = data_q[b];
      if (io_bank_r == BW'(b)) n_iv_in = ~ext_rd_data[b*DW +: DW];
    end
  end

  assign ext_wr_valid = ~fifo_empty;
  assign ext_wr_bank  = head.bank;
  assign ext_wr_addr  = head.addr;
  assign ext_wr_data  = head.data;
  assign io_stall     = (fifo_count == CW'(FIFO_DEPTH));
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_iv_bus_ctrl.sv
// Self-checking bench for iv_bus_ctrl (NBANK=3, DW=8, FIFO_DEPTH=4).
module tb_iv_bus_ctrl;

  localparam int DW    = 8;
  localparam int NBANK = 3;
  localparam int DEPTH = 4;
  localparam int BW    = 2;

  logic                clk, rst;
  logic                io_sc, io_wc, ext_wr_ready, ovf_clr;
  logic [BW-1:0]       io_bank_w, io_bank_r;
  logic [DW-1:0]       n_iv_out, n_iv_in;
  logic [NBANK*DW-1:0] ext_rd_data, bank_addr, bank_dout;
  logic                ext_wr_valid, io_stall, ovf;
  logic [BW-1:0]       ext_wr_bank;
  logic [DW-1:0]       ext_wr_addr, ext_wr_data;

  iv_bus_ctrl #(.DW(DW), .NBANK(NBANK), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_sc(io_sc), .io_wc(io_wc), .io_bank_w(io_bank_w),
    .io_bank_r(io_bank_r), .n_iv_out(n_iv_out), .n_iv_in(n_iv_in),
    .ext_rd_data(ext_rd_data), .bank_addr(bank_addr), .bank_dout(bank_dout),
    .ext_wr_valid(ext_wr_valid), .ext_wr_ready(ext_wr_ready), .ext_wr_bank(ext_wr_bank),
    .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data), .io_stall(io_stall),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [BW-1:0]       bank_r;
    logic [NBANK*DW-1:0] rd;
    logic [DW-1:0]       exp;
  } rd_vec_t;

  ent_t          q[$];
  logic [DW-1:0] addr_m [NBANK];
  logic [DW-1:0] data_m [NBANK];
  logic          ovf_m;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NBANK; i++) begin
      addr_m[i] = '0;
      data_m[i] = '0;
    end
    ovf_m = 1'b0;
  endtask

  // Reference: apply the current inputs to the abstract state as of the coming edge.
  task automatic model_step();
    logic [DW-1:0] iv, a;
    bit            ok, popm, dropm;
    int            bw;
    bw    = int'(io_bank_w);
    iv    = ~n_iv_out;
    ok    = bw < NBANK;
    popm  = (q.size() > 0) && ext_wr_ready;
    dropm = 0;
    if (popm) void'(q.pop_front());
    if (ok && io_wc) begin
      a = io_sc ? iv : addr_m[bw];
      if (q.size() < DEPTH) q.push_back('{bank: io_bank_w, addr: a, data: iv});
      else dropm = 1;
    end
    if (dropm) ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
    if (ok) begin
      if (io_sc) addr_m[bw] = iv;
`ifdef IV_BUS_AUTOINC_EN
      else if (io_wc) addr_m[bw] = a + 8'd1;
`endif
      if (io_wc) data_m[bw] = iv;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NBANK*DW-1:0] ea, ed;
    logic [DW-1:0]       er;
    for (int i = 0; i < NBANK; i++) begin
      ea[i*DW +: DW] = addr_m[i];
      ed[i*DW +: DW] = data_m[i];
    end
    er = (int'(io_bank_r) < NBANK) ? ~ext_rd_data[int'(io_bank_r)*DW +: DW] : 8'hFF;
    chk({tag, ".bank_addr"}, 32'(bank_addr), 32'(ea));
    chk({tag, ".bank_dout"}, 32'(bank_dout), 32'(ed));
    chk({tag, ".valid"}, 32'(ext_wr_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk({tag, ".head"}, 32'({ext_wr_bank, ext_wr_addr, ext_wr_data}),
                          32'(q[0]));
    chk({tag, ".stall"}, 32'(io_stall), 32'(q.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(ovf), 32'(ovf_m));
    chk({tag, ".n_iv_in"}, 32'(n_iv_in), 32'(er));
  endtask

  task automatic step(input string tag, input logic sc, input logic wc, input logic [BW-1:0] bw,
                      input logic [DW-1:0] nout, input logic rdy, input logic clr);
    io_sc = sc; io_wc = wc; io_bank_w = bw; n_iv_out = nout;
    ext_wr_ready = rdy; ovf_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(tag, 0, 0, 0, 8'hFF, 1, 0);
    chk({tag, ".empty"}, 32'(ext_wr_valid), 32'(0));
  endtask

  rd_vec_t       rd_tab [5];
  logic [DW-1:0] exp5 [3];

  initial begin
    rd_tab[0] = '{bank_r: 2'd0, rd: 24'h00003C, exp: 8'hC3};
    rd_tab[1] = '{bank_r: 2'd1, rd: 24'h00A500, exp: 8'h5A};
    rd_tab[2] = '{bank_r: 2'd2, rd: 24'h7E0000, exp: 8'h81};
    rd_tab[3] = '{bank_r: 2'd3, rd: 24'h123456, exp: 8'hFF};
    rd_tab[4] = '{bank_r: 2'd0, rd: 24'hFFFFFF, exp: 8'h00};
`ifdef IV_BUS_AUTOINC_EN
    exp5[0] = 8'hFE; exp5[1] = 8'hFF; exp5[2] = 8'h00;
`else
    exp5[0] = 8'hFE; exp5[1] = 8'hFE; exp5[2] = 8'hFE;
`endif

    rst = 1'b1; io_sc = 0; io_wc = 0; io_bank_w = 0; io_bank_r = 0; n_iv_out = 8'hFF;
    ext_rd_data = '0; ext_wr_ready = 0; ovf_clr = 0;
    model_reset();
    #12;
    chk("reset.valid", 32'(ext_wr_valid), 32'(0));
    chk("reset.addr", 32'(bank_addr), 32'(0));
    chk("reset.dout", 32'(bank_dout), 32'(0));
    chk("reset.stall", 32'(io_stall), 32'(0));
    chk("reset.ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // SC then WC on bank 1; head visible right after the WC edge.
    step("t1.sc", 1, 0, 1, 8'hF0, 0, 0);
    step("t1.wc", 0, 1, 1, 8'hA5, 0, 0);
`ifdef IV_BUS_AUTOINC_EN
    chk("t1.addr_latch", 32'(bank_addr[15:8]), 32'(8'h10));
`else
    chk("t1.addr_latch", 32'(bank_addr[15:8]), 32'(8'h0F));
`endif
    chk("t1.dout_latch", 32'(bank_dout[15:8]), 32'(8'h5A));
    chk("t1.head", 32'({ext_wr_valid, ext_wr_bank, ext_wr_addr, ext_wr_data}),
        32'({1'b1, 2'd1, 8'h0F, 8'h5A}));
    drain("t1.drain");

    // Fill to full, overflow, drop-with-clear keeps the flag, then clear.
    for (int i = 0; i < 4; i++) step("t2.fill", 0, 1, 2, 8'(8'h10 + i), 0, 0);
    chk("t2.stall_full", 32'(io_stall), 32'(1));
    chk("t2.ovf_before", 32'(ovf), 32'(0));
    step("t2.drop", 0, 1, 2, 8'h77, 0, 0);
    chk("t2.ovf_set", 32'(ovf), 32'(1));
    chk("t2.dout_still", 32'(bank_dout[23:16]), 32'(8'h88));
    step("t2.drop_clr", 0, 1, 2, 8'h66, 0, 1);
    chk("t2.ovf_hold", 32'(ovf), 32'(1));
    step("t2.clr", 0, 0, 0, 8'hFF, 0, 1);
    chk("t2.ovf_clr", 32'(ovf), 32'(0));

    // Full FIFO with simultaneous pop and push.
    step("t3.popush", 0, 1, 0, 8'h33, 1, 0);
    chk("t3.stall", 32'(io_stall), 32'(1));
    chk("t3.ovf", 32'(ovf), 32'(0));
    drain("t3.drain");

    // Out-of-range bank: no latch change, no push.
    step("tb3.sc_wc", 1, 1, 3, 8'h00, 0, 0);
    chk("tb3.novalid", 32'(ext_wr_valid), 32'(0));

    // Read mux vectors.
    for (int i = 0; i < 5; i++) begin
      io_bank_r = rd_tab[i].bank_r;
      ext_rd_data = rd_tab[i].rd;
      #1;
      chk($sformatf("t4.rd%0d", i), 32'(n_iv_in), 32'(rd_tab[i].exp));
    end

    // Address auto-increment (or not) across three writes.
    step("t5.sc", 1, 0, 0, 8'h01, 0, 0);
    for (int i = 0; i < 3; i++) step("t5.wc", 0, 1, 0, 8'(i), 0, 0);
`ifdef IV_BUS_AUTOINC_EN
    chk("t5.addr_latch", 32'(bank_addr[7:0]), 32'(8'h01));
`else
    chk("t5.addr_latch", 32'(bank_addr[7:0]), 32'(8'hFE));
`endif
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5.entry%0d", i), 32'(ext_wr_addr), 32'(exp5[i]));
      step("t5.pop", 0, 0, 0, 8'hFF, 1, 0);
    end

    // Asynchronous reset with queued entries.
    for (int i = 0; i < 3; i++) step("t6.fill", 0, 1, 1, 8'(8'h40 + i), 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6.valid_async", 32'(ext_wr_valid), 32'(0));
    chk("t6.addr", 32'(bank_addr), 32'(0));
    chk("t6.dout", 32'(bank_dout), 32'(0));
    model_reset();
    io_wc = 0; io_sc = 0; ext_wr_ready = 1;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step("t6.after", 0, 0, 0, 8'hFF, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ext_rd_data = 24'($urandom());
      io_bank_r   = 2'($urandom_range(0, 3));
      step("rnd", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 6),
           2'($urandom_range(0, 3)), 8'($urandom()), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
